bf16_mul_array: RTL
===================

# bf16_mul_array

Multi-lane, pipelined bf16 multiplier with a valid/ready stream interface. Multiplies LANES independent operand pairs per beat, with IEEE-style special-value handling, overflow/underflow saturation and selectable rounding. It is the throughput-oriented successor to the single-lane combinational bf16 multiplier and feeds the accelerator's message/aggregation datapath at one beat per cycle.

## Interface
- LANES, 4: number of parallel bf16 multiplier lanes (1..16).
- TAG_W, 8: width of the sideband tag carried alongside each beat.

- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_a  input  16*LANES  operand A; lane i is in_a[16*i+15:16*i].
- in_b  input  16*LANES  operand B, same packing.
- in_mask  input  LANES  lane enable; 0 forces that lane's result to 0x0000 and its flags to 0.
- in_tag  input  TAG_W  opaque sideband, returned unchanged.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the beat.
- out_p  output  16*LANES  products, same packing as in_a.
- out_tag  output  TAG_W  tag of this beat.
- out_ovf  output  LANES  lane result saturated to ±inf by exponent overflow.
- out_unf  output  LANES  lane result flushed to ±0 by exponent underflow.
- out_nan  output  LANES  lane result is NaN.

## Operation
- Transfer happens on a cycle where valid && ready. Beats leave in acceptance order; none dropped or duplicated.
- Three register stages, each with its own valid bit:
  - S1: unpack, sign = sa^sb, special-case classification, 10-bit signed exponent ea+eb-127, and 8x8 significand product.
  - S2: normalisation (if product bit 15 is set, shift right by one and add 1 to the exponent), then rounding.
  - S3: post-round renormalisation, saturation and packing; this is the output register.
- Stage k loads when it is empty or its contents advance in the same cycle. in_ready = !S1.valid || S1 advances. This stall path is combinational.
- Significand: exponent 0 treats the operand as zero (denormals flushed), so the result is 0 with the sign computed as above. Otherwise the hidden bit is 1.
- Special cases (sign = sa^sb unless stated):
  - Either operand is NaN, or inf×0: result is canonical 0x7FC0 with nan=1.
  - inf × finite nonzero: result is ±inf (0x7F80 with sign).
- Rounding: kept mantissa is 7 bits. Guard is the next lower bit; sticky is the OR of all remaining bits.
- If rounding carries the mantissa to 0x80, the mantissa becomes 0 and the exponent is incremented.
- After rounding:
  - Exponent ≥ 255: result is ±inf, ovf=1.
  - Exponent ≤ 0: result is ±0, unf=1.
- Flags are per beat, not sticky.

## Timing
- Latency: 3 cycles from input acceptance to out_valid, with out_ready held high.
- Throughput: 1 beat per cycle.
- Capacity: 3 beats. With out_ready low, the pipeline fills and in_ready falls in the cycle after the third beat is accepted.
- out_p, out_tag and flags stay stable while out_valid && !out_ready.
- In-flight state: while rst_n is low at a clock edge, all stage valid bits clear and all data registers clear to 0.
- Outputs during reset: out_valid=0, out_p=0, out_tag=0, flags=0, in_ready=0.
- Reset asserted mid-operation discards in-flight beats. in_ready returns to 1 in the first cycle after rst_n is sampled high.
- Simultaneous accept and emit with a full pipeline is allowed: the beat is accepted and all stages shift.

## Configuration
- BF16_MUL_RNE_EN defined: round-to-nearest-even. Increment the mantissa when guard && (sticky || lsb).
- Undefined: truncation. Guard and sticky are ignored, and results are bit-identical to the previous-generation multiplier for finite in-range products.
- Special-case handling and saturation are identical in both builds.

## Test plan
- LANES=4, lane0 0x3F80×0x3FC0, lane1 0x4000×0x4040, out_ready=1 → after 3 cycles out_p lane0=0x3FC0, lane1=0x40C0, flags 0.
- 0x3FC1×0x3FC1 → 0x4012 with BF16_MUL_RNE_EN defined, 0x4011 without it.
- 0x7F00×0x4000 → 0x7F80 with ovf=1. 0x0080×0x0080 → 0x0000 with unf=1. 0xFF00×0x4000 → 0xFF80 with ovf=1.
- 0x7F80×0x0000 → 0x7FC0 with nan=1. 0x7FC1×0x3F80 → 0x7FC0 with nan=1. 0x7F80×0xBF80 → 0xFF80 with nan=0.
- Backpressure: out_ready=0 for 6 cycles while offering tags 1..5 back-to-back.
  - Required: exactly 3 accepted and in_ready low after that.
  - On release, tags 1..5 emerge in order with correct products and no gaps once flowing.
- Reset pulse (one cycle, rst_n=0) with 2 beats in flight → out_valid=0 and all outputs 0 on the next cycle. The in-flight beats never appear; the first post-reset beat emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/bf16_mul_array_if.sv
// -----------------------------------------------------------------------------
// bf16_mul_array_if
//
// Purpose : Bundles the two valid/ready streams of bf16_mul_array (operand
//           beats in, product beats out) into one interface.
//
// Ports / signals (LANES lanes, 16 bits per lane, lane i at [16*i+15:16*i]):
//   in_valid  : producer -> block  input beat present
//   in_ready  : block -> producer  block accepts the beat this cycle
//   in_a/in_b : producer -> block  packed bf16 operands
//   in_mask   : producer -> block  per-lane enable (0 forces result 0, flags 0)
//   in_tag    : producer -> block  opaque sideband, returned unchanged
//   out_valid : block -> consumer  result beat present
//   out_ready : consumer -> block  consumer accepts the beat
//   out_p     : block -> consumer  packed bf16 products
//   out_tag   : block -> consumer  tag of this beat
//   out_ovf/out_unf/out_nan : block -> consumer  per-lane result flags
//
// Modports: master = the environment (drives operands, consumes results),
//           slave  = bf16_mul_array.
// -----------------------------------------------------------------------------
interface bf16_mul_array_if #(
    parameter int LANES = 4,
    parameter int TAG_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*LANES-1:0]   in_a;
    logic [16*LANES-1:0]   in_b;
    logic [LANES-1:0]      in_mask;
    logic [TAG_W-1:0]      in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic [16*LANES-1:0]   out_p;
    logic [TAG_W-1:0]      out_tag;
    logic [LANES-1:0]      out_ovf;
    logic [LANES-1:0]      out_unf;
    logic [LANES-1:0]      out_nan;

    modport master (
        output in_valid, in_a, in_b, in_mask, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, out_ovf, out_unf, out_nan
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mask, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, out_ovf, out_unf, out_nan
    );
endinterface

// File: rtl/bf16_mul_array.sv
// -----------------------------------------------------------------------------
// bf16_mul_array
//
// Purpose : LANES-wide, three-stage pipelined bf16 multiplier with a
//           valid/ready stream interface. One beat per cycle, latency 3,
//           capacity 3 beats. Denormal inputs are flushed to zero, NaN/inf
//           are handled IEEE-style, exponent overflow saturates to +-inf and
//           underflow flushes to +-0, each with a per-lane flag.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset; clears all stage valids and data
//   bus   : bf16_mul_array_if.slave (operand stream in, product stream out)
//
// Configuration macro:
//   BF16_MUL_RNE_EN : defined -> round-to-nearest-even,
//                     undefined -> truncation (guard/sticky ignored).
//
// Handshake: a beat moves across a boundary on a cycle where valid && ready.
// A producer holds valid and data steady until accepted; valid never depends
// on ready. Each stage k has its own valid bit and loads when it is empty or
// its current contents move on in the same cycle, so in_ready is a purely
// combinational function of out_ready and the three stage valid bits.
//
// Pipeline:
//   S1 : unpack, sign, special-case classes, exponent ea+eb-127, 8x8 product
//   S2 : normalise (product bit 15) and round to 7 kept mantissa bits
//   S3 : rounding carry, saturation, special-value packing (output register)
// -----------------------------------------------------------------------------
module bf16_mul_array #(
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    bf16_mul_array_if.slave    bus
);

`ifdef BF16_MUL_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Stage enables / handshake
    // -------------------------------------------------------------------------
    logic r1_v, r2_v, r3_v;
    logic w_en1, w_en2, w_en3;
    logic w_acc;

    assign w_en3 = !r3_v || bus.out_ready;
    assign w_en2 = !r2_v || w_en3;
    assign w_en1 = !r1_v || w_en2;

    // Held low while reset is asserted so nothing is accepted into a pipeline
    // that is being cleared.
    assign bus.in_ready = rst_n && w_en1;
    assign w_acc        = bus.in_valid && bus.in_ready;

    // -------------------------------------------------------------------------
    // S1 combinational: unpack and classify
    // -------------------------------------------------------------------------
    logic [7:0]        w_ea   [LANES];
    logic [7:0]        w_eb   [LANES];
    logic [6:0]        w_ma   [LANES];
    logic [6:0]        w_mb   [LANES];
    logic [LANES-1:0]  w_a_zero, w_a_inf, w_a_nan;
    logic [LANES-1:0]  w_b_zero, w_b_inf, w_b_nan;
    logic [LANES-1:0]  w1_sign, w1_nan, w1_inf, w1_zero;
    logic [9:0]        w1_exp  [LANES];
    logic [15:0]       w1_prod [LANES];

    always_comb begin
        w_ea     = '{default: '0};
        w_eb     = '{default: '0};
        w_ma     = '{default: '0};
        w_mb     = '{default: '0};
        w_a_zero = '0;
        w_a_inf  = '0;
        w_a_nan  = '0;
        w_b_zero = '0;
        w_b_inf  = '0;
        w_b_nan  = '0;
        w1_sign  = '0;
        w1_nan   = '0;
        w1_inf   = '0;
        w1_zero  = '0;
        w1_exp   = '{default: '0};
        w1_prod  = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            w_ea[i] = bus.in_a[16*i+7 +: 8];
            w_eb[i] = bus.in_b[16*i+7 +: 8];
            w_ma[i] = bus.in_a[16*i +: 7];
            w_mb[i] = bus.in_b[16*i +: 7];

            // Exponent 0 covers both true zero and denormals: both read as 0.
            w_a_zero[i] = (w_ea[i] == 8'd0);
            w_b_zero[i] = (w_eb[i] == 8'd0);
            w_a_inf[i]  = (&w_ea[i]) && (w_ma[i] == 7'd0);
            w_b_inf[i]  = (&w_eb[i]) && (w_mb[i] == 7'd0);
            w_a_nan[i]  = (&w_ea[i]) && (w_ma[i] != 7'd0);
            w_b_nan[i]  = (&w_eb[i]) && (w_mb[i] != 7'd0);

            w1_sign[i] = bus.in_a[16*i+15] ^ bus.in_b[16*i+15];
            // inf x 0 is invalid and joins the NaN class.
            w1_nan[i]  = w_a_nan[i] || w_b_nan[i] ||
                         (w_a_inf[i] && w_b_zero[i]) ||
                         (w_b_inf[i] && w_a_zero[i]);
            w1_inf[i]  = (w_a_inf[i] || w_b_inf[i]) && !w1_nan[i];
            w1_zero[i] = (w_a_zero[i] || w_b_zero[i]) && !w1_nan[i];

            // Two's complement, range -127..381, fits 10 bits signed.
            w1_exp[i]  = {2'b00, w_ea[i]} + {2'b00, w_eb[i]} - 10'd127;
            w1_prod[i] = {8'd0, 1'b1, w_ma[i]} * {8'd0, 1'b1, w_mb[i]};
        end
    end

    // -------------------------------------------------------------------------
    // S1 registers
    // -------------------------------------------------------------------------
    logic [LANES-1:0]  r1_sign, r1_nan, r1_inf, r1_zero, r1_mask;
    logic [9:0]        r1_exp  [LANES];
    logic [15:0]       r1_prod [LANES];
    logic [TAG_W-1:0]  r1_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_v    <= 1'b0;
            r1_sign <= '0;
            r1_nan  <= '0;
            r1_inf  <= '0;
            r1_zero <= '0;
            r1_mask <= '0;
            r1_tag  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r1_exp[i]  <= '0;
                r1_prod[i] <= '0;
            end
        end else if (w_en1) begin
            r1_v    <= w_acc;
            r1_sign <= w1_sign;
            r1_nan  <= w1_nan;
            r1_inf  <= w1_inf;
            r1_zero <= w1_zero;
            r1_mask <= bus.in_mask;
            r1_tag  <= bus.in_tag;
            for (int i = 0; i < LANES; i++) begin
                r1_exp[i]  <= w1_exp[i];
                r1_prod[i] <= w1_prod[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2 combinational: normalise and round
    // -------------------------------------------------------------------------
    // Product of two 1.7 significands is in [1,4): bit 15 set means the value
    // is >= 2, so the kept bits start one position higher and exponent +1.
    logic [6:0]        w2_kept [LANES];
    logic [LANES-1:0]  w2_guard, w2_sticky, w2_inc;
    logic [7:0]        w2_mant [LANES];
    logic [9:0]        w2_exp  [LANES];

    always_comb begin
        w2_kept   = '{default: '0};
        w2_guard  = '0;
        w2_sticky = '0;
        w2_inc    = '0;
        w2_mant   = '{default: '0};
        w2_exp    = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            if (r1_prod[i][15]) begin
                w2_kept[i]   = r1_prod[i][14:8];
                w2_guard[i]  = r1_prod[i][7];
                w2_sticky[i] = |r1_prod[i][6:0];
            end else begin
                w2_kept[i]   = r1_prod[i][13:7];
                w2_guard[i]  = r1_prod[i][6];
                w2_sticky[i] = |r1_prod[i][5:0];
            end
            w2_exp[i] = r1_exp[i] + {9'd0, r1_prod[i][15]};
            // In the truncating build RNE_EN is 0 and the increment vanishes.
            w2_inc[i]  = RNE_EN && w2_guard[i] && (w2_sticky[i] || w2_kept[i][0]);
            // Bit 7 of the 8-bit result is the rounding carry out (0x80).
            w2_mant[i] = {1'b0, w2_kept[i]} + {7'd0, w2_inc[i]};
        end
    end

    // -------------------------------------------------------------------------
    // S2 registers
    // -------------------------------------------------------------------------
    logic [LANES-1:0]  r2_sign, r2_nan, r2_inf, r2_zero, r2_mask;
    logic [9:0]        r2_exp  [LANES];
    logic [7:0]        r2_mant [LANES];
    logic [TAG_W-1:0]  r2_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r2_v    <= 1'b0;
            r2_sign <= '0;
            r2_nan  <= '0;
            r2_inf  <= '0;
            r2_zero <= '0;
            r2_mask <= '0;
            r2_tag  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r2_exp[i]  <= '0;
                r2_mant[i] <= '0;
            end
        end else if (w_en2) begin
            r2_v    <= r1_v;
            r2_sign <= r1_sign;
            r2_nan  <= r1_nan;
            r2_inf  <= r1_inf;
            r2_zero <= r1_zero;
            r2_mask <= r1_mask;
            r2_tag  <= r1_tag;
            for (int i = 0; i < LANES; i++) begin
                r2_exp[i]  <= w2_exp[i];
                r2_mant[i] <= w2_mant[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // S3 combinational: rounding carry, saturation, packing
    // -------------------------------------------------------------------------
    logic signed [9:0]  w3_exp [LANES];
    logic [16*LANES-1:0] w3_p;
    logic [LANES-1:0]    w3_ovf, w3_unf, w3_nan;

    always_comb begin
        w3_exp = '{default: '0};
        w3_p   = '0;
        w3_ovf = '0;
        w3_unf = '0;
        w3_nan = '0;
        for (int i = 0; i < LANES; i++) begin
            // A carry to 0x80 leaves mantissa bits [6:0] at zero already, so
            // only the exponent needs the bump.
            w3_exp[i] = r2_exp[i] + {9'd0, r2_mant[i][7]};
            if (!r2_mask[i]) begin
                w3_p[16*i +: 16] = 16'h0000;
            end else if (r2_nan[i]) begin
                w3_p[16*i +: 16] = 16'h7FC0;
                w3_nan[i]        = 1'b1;
            end else if (r2_inf[i]) begin
                w3_p[16*i +: 16] = {r2_sign[i], 15'h7F80};
            end else if (r2_zero[i]) begin
                w3_p[16*i +: 16] = {r2_sign[i], 15'h0000};
            end else if (w3_exp[i] >= 10'sd255) begin
                w3_p[16*i +: 16] = {r2_sign[i], 15'h7F80};
                w3_ovf[i]        = 1'b1;
            end else if (w3_exp[i] <= 10'sd0) begin
                w3_p[16*i +: 16] = {r2_sign[i], 15'h0000};
                w3_unf[i]        = 1'b1;
            end else begin
                w3_p[16*i +: 16] = {r2_sign[i], w3_exp[i][7:0], r2_mant[i][6:0]};
            end
        end
    end

    // -------------------------------------------------------------------------
    // S3 registers (output register)
    // -------------------------------------------------------------------------
    logic [16*LANES-1:0] r3_p;
    logic [TAG_W-1:0]    r3_tag;
    logic [LANES-1:0]    r3_ovf, r3_unf, r3_nan;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r3_v   <= 1'b0;
            r3_p   <= '0;
            r3_tag <= '0;
            r3_ovf <= '0;
            r3_unf <= '0;
            r3_nan <= '0;
        end else if (w_en3) begin
            r3_v   <= r2_v;
            r3_p   <= w3_p;
            r3_tag <= r2_tag;
            r3_ovf <= w3_ovf;
            r3_unf <= w3_unf;
            r3_nan <= w3_nan;
        end
    end

    // Outputs read as zero for the whole time reset is held, including the
    // cycle before the first reset edge clears the registers.
    assign bus.out_valid = rst_n && r3_v;
    assign bus.out_p     = rst_n ? r3_p   : '0;
    assign bus.out_tag   = rst_n ? r3_tag : '0;
    assign bus.out_ovf   = rst_n ? r3_ovf : '0;
    assign bus.out_unf   = rst_n ? r3_unf : '0;
    assign bus.out_nan   = rst_n ? r3_nan : '0;

endmodule
